// File: rtl/ifu_prefetch_if.sv
// Fetch-unit channels: redirect/reset PC, fetch CMD/RSP bus and decode delivery.
// The master modport is the fetch unit; the slave modport is core + instruction bus.
interface ifu_prefetch_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] i_reset_pc;
    logic          i_jump_valid;
    logic [AW-1:0] i_jump_pc;

    logic          o_cmd_valid;
    logic          i_cmd_ready;
    logic [AW-1:0] o_cmd_pc;

    logic          i_rsp_valid;
    logic          o_rsp_ready;
    logic          i_rsp_err;
    logic [DW-1:0] i_rsp_instr;

    logic          o_ins_valid;
    logic          i_ins_ready;
    logic [AW-1:0] o_ins_pc;
    logic [DW-1:0] o_ins_instr;
    logic          o_ins_err;

    modport master (
        input  i_reset_pc, i_jump_valid, i_jump_pc,
        input  i_cmd_ready, i_rsp_valid, i_rsp_err, i_rsp_instr, i_ins_ready,
        output o_cmd_valid, o_cmd_pc, o_rsp_ready,
        output o_ins_valid, o_ins_pc, o_ins_instr, o_ins_err
    );

    modport slave (
        output i_reset_pc, i_jump_valid, i_jump_pc,
        output i_cmd_ready, i_rsp_valid, i_rsp_err, i_rsp_instr, i_ins_ready,
        input  o_cmd_valid, o_cmd_pc, o_rsp_ready,
        input  o_ins_valid, o_ins_pc, o_ins_instr, o_ins_err
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: credit-limited fetch issue, in-order response
// buffering, and jump redirect that flushes the buffer and drops stale responses.
module ifu_prefetch #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int PC_INC = 4
) (
    input logic          clk,
    input logic          rst,
    ifu_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [AW-1:0] pc_reg;
    logic [CW-1:0] pend_reg;
    logic [CW-1:0] drop_reg;
    logic [CW-1:0] cnt_reg;
    logic          halted_reg;

    // PC of each outstanding request, in issue order
    logic [AW-1:0] pcq_mem [DEPTH];
    logic [PW-1:0] pcq_wr_reg;
    logic [PW-1:0] pcq_rd_reg;

    logic [AW-1:0] buf_pc_mem    [DEPTH];
    logic [DW-1:0] buf_instr_mem [DEPTH];
    logic          buf_err_mem   [DEPTH];
    logic [PW-1:0] buf_wr_reg;
    logic [PW-1:0] buf_rd_reg;

    logic [CW:0]   credit_used;
    logic          cmd_valid;
    logic          cmd_fire;
    logic          rsp_fire;
    logic          discard;
    logic          push;
    logic          ins_valid;
    logic          pop;
    logic [CW-1:0] pend_next;

    always_comb begin
        credit_used = {1'b0, pend_reg} + {1'b0, cnt_reg};
        cmd_valid   = !rst && !halted_reg && !bus.i_jump_valid && (credit_used < DEPTH_C);
        cmd_fire    = cmd_valid && bus.i_cmd_ready;
        // A response with nothing outstanding is a bus protocol error and is ignored
        rsp_fire    = bus.i_rsp_valid && (pend_reg != '0);
        discard     = rsp_fire && (drop_reg != '0);
        push        = rsp_fire && (drop_reg == '0) && !bus.i_jump_valid;
        ins_valid   = !rst && (cnt_reg != '0);
        pop         = ins_valid && bus.i_ins_ready && !bus.i_jump_valid;
        pend_next   = pend_reg + CW'(cmd_fire) - CW'(rsp_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= bus.i_reset_pc;
            pend_reg   <= '0;
            drop_reg   <= '0;
            cnt_reg    <= '0;
            halted_reg <= 1'b0;
            pcq_wr_reg <= '0;
            pcq_rd_reg <= '0;
            buf_wr_reg <= '0;
            buf_rd_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            if (cmd_fire) pcq_wr_reg <= pcq_wr_reg + 1'b1;
            if (rsp_fire) pcq_rd_reg <= pcq_rd_reg + 1'b1;

            if (bus.i_jump_valid) begin
                // Everything still in flight belongs to the old stream
                pc_reg     <= bus.i_jump_pc;
                drop_reg   <= pend_next;
                cnt_reg    <= '0;
                buf_rd_reg <= buf_wr_reg;
                halted_reg <= 1'b0;
            end else begin
                if (cmd_fire) pc_reg <= pc_reg + AW'(PC_INC);
                if (discard) drop_reg <= drop_reg - 1'b1;
                if (push) buf_wr_reg <= buf_wr_reg + 1'b1;
                if (pop) buf_rd_reg <= buf_rd_reg + 1'b1;
                cnt_reg <= cnt_reg + CW'(push) - CW'(pop);
                if (push && bus.i_rsp_err) halted_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) pcq_mem[pcq_wr_reg] <= pc_reg;
        if (push) begin
            buf_pc_mem[buf_wr_reg]    <= pcq_mem[pcq_rd_reg];
            buf_instr_mem[buf_wr_reg] <= bus.i_rsp_instr;
            buf_err_mem[buf_wr_reg]   <= bus.i_rsp_err;
        end
    end

    assign bus.o_cmd_valid = cmd_valid;
    assign bus.o_cmd_pc    = pc_reg;
    assign bus.o_rsp_ready = 1'b1;
    assign bus.o_ins_valid = ins_valid;
    assign bus.o_ins_pc    = buf_pc_mem[buf_rd_reg];
    assign bus.o_ins_instr = buf_instr_mem[buf_rd_reg];
    assign bus.o_ins_err   = buf_err_mem[buf_rd_reg];
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed table and corner sequences plus randomized traffic,
// all compared against a queue-based reference of in-flight fetches and buffered instructions.
module tb_ifu_prefetch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.AW(AW), .DW(DW)) bus ();

    ifu_prefetch #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct { logic [31:0] pc; logic err; } env_t;
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ins_t;
    typedef struct {
        bit crdy; bit rv; bit irdy;
        bit e_cv; logic [31:0] e_cpc;
        bit e_iv; logic [31:0] e_ipc;
    } vec_t;

    env_t env_q[$];
    fl_t  m_fl[$];
    ins_t m_buf[$];
    logic [31:0] m_pc = '0;
    bit m_halt = 0;

    int checks = 0;
    int failures = 0;

    bit t_rst = 1, t_jump = 0, t_crdy = 0, t_rv = 0, t_irdy = 0;
    logic [31:0] t_jpc = '0, t_rpc = '0, err_pc = 32'h1;
    int err_mod = 0;

    bit o_cv, o_iv, o_ierr;
    logic [31:0] o_cpc, o_ipc;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        bit e_cv = 0, e_iv = 0, rfire, dut_cfire;
        logic [31:0] rinstr;
        logic rerr;
        fl_t f;
        ins_t h;
        env_t ev;
        rst = t_rst;
        bus.i_reset_pc   = t_rpc;
        bus.i_jump_valid = t_jump;
        bus.i_jump_pc    = t_jpc;
        bus.i_cmd_ready  = t_crdy;
        bus.i_ins_ready  = t_irdy;
        bus.i_rsp_valid  = t_rv;
        if (env_q.size() > 0) begin
            rinstr = instr_of(env_q[0].pc);
            rerr   = env_q[0].err;
        end else begin
            rinstr = $urandom;
            rerr   = 1'($urandom);
        end
        bus.i_rsp_instr = rinstr;
        bus.i_rsp_err   = rerr;
        @(negedge clk);
        o_cv = bus.o_cmd_valid; o_cpc = bus.o_cmd_pc;
        o_iv = bus.o_ins_valid; o_ipc = bus.o_ins_pc; o_ierr = bus.o_ins_err;
        if (t_rst) begin
            chk("rst_cmd_valid", 64'(o_cv), 64'(0));
            chk("rst_ins_valid", 64'(o_iv), 64'(0));
        end else begin
            e_cv = !m_halt && !t_jump && (m_fl.size() + m_buf.size() < DEPTH);
            e_iv = m_buf.size() > 0;
            chk("cmd_valid", 64'(o_cv), 64'(e_cv));
            if (e_cv) chk("cmd_pc", 64'(o_cpc), 64'(m_pc));
            chk("ins_valid", 64'(o_iv), 64'(e_iv));
            if (e_iv) begin
                chk("ins_pc", 64'(o_ipc), 64'(m_buf[0].pc));
                chk("ins_instr", 64'(bus.o_ins_instr), 64'(m_buf[0].instr));
                chk("ins_err", 64'(o_ierr), 64'(m_buf[0].err));
            end
            chk("rsp_ready", 64'(bus.o_rsp_ready), 64'(1));
        end
        dut_cfire = bus.o_cmd_valid && t_crdy;
        @(posedge clk);
        if (t_rst) begin
            m_pc = t_rpc; m_halt = 0;
            m_fl.delete(); m_buf.delete(); env_q.delete();
        end else begin
            rfire = t_rv && (m_fl.size() > 0);
            if (t_jump) begin
                if (rfire) void'(m_fl.pop_front());
                foreach (m_fl[i]) m_fl[i].stale = 1;
                m_buf.delete();
                m_halt = 0;
                m_pc = t_jpc;
            end else begin
                if (e_iv && t_irdy) void'(m_buf.pop_front());
                if (rfire) begin
                    f = m_fl.pop_front();
                    if (!f.stale) begin
                        h.pc = f.pc; h.instr = rinstr; h.err = rerr;
                        m_buf.push_back(h);
                        if (rerr) m_halt = 1;
                    end
                end
                if (e_cv && t_crdy) begin
                    f.pc = m_pc; f.stale = 0;
                    m_fl.push_back(f);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (t_rv && env_q.size() > 0) void'(env_q.pop_front());
            if (dut_cfire) begin
                ev.pc  = o_cpc;
                ev.err = (o_cpc == err_pc) || (err_mod != 0 && $urandom_range(err_mod - 1) == 0);
                env_q.push_back(ev);
            end
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        t_rst = 1; t_rpc = pc; t_jump = 0; t_rv = 0; t_crdy = 0; t_irdy = 0;
        cycle();
        cycle();
        t_rst = 0;
    endtask

    initial begin
        vec_t vt[6];
        int nf;
        bit found;
        bit rv_pat[4];

        vt[0] = '{1, 0, 1, 1, 32'h1000, 0, 32'h0};
        vt[1] = '{1, 1, 1, 1, 32'h1004, 0, 32'h0};
        vt[2] = '{1, 1, 1, 1, 32'h1008, 1, 32'h1000};
        vt[3] = '{1, 1, 1, 1, 32'h100C, 1, 32'h1004};
        vt[4] = '{1, 1, 1, 1, 32'h1010, 1, 32'h1008};
        vt[5] = '{1, 1, 1, 1, 32'h1014, 1, 32'h100C};

        // Streaming from reset with an always-ready, 1-cycle-latency bus
        do_reset(32'h1000);
        for (int i = 0; i < 6; i++) begin
            t_crdy = vt[i].crdy; t_rv = vt[i].rv; t_irdy = vt[i].irdy;
            cycle();
            chk("tbl_cmd_valid", 64'(o_cv), 64'(vt[i].e_cv));
            if (vt[i].e_cv) chk("tbl_cmd_pc", 64'(o_cpc), 64'(vt[i].e_cpc));
            chk("tbl_ins_valid", 64'(o_iv), 64'(vt[i].e_iv));
            if (vt[i].e_iv) chk("tbl_ins_pc", 64'(o_ipc), 64'(vt[i].e_ipc));
        end

        // Decode backpressure: credits cap issue at DEPTH, one pop frees one
        do_reset(32'h1000);
        t_crdy = 1; t_irdy = 0; nf = 0;
        for (int i = 0; i < 10; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
            if (o_cv && t_crdy) nf++;
        end
        chk("bp_issue_count", 64'(nf), 64'(4));
        t_irdy = 1; t_rv = 0;
        cycle();
        if (o_cv && t_crdy) nf++;
        t_irdy = 0;
        for (int i = 0; i < 6; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
            if (o_cv && t_crdy) nf++;
        end
        chk("bp_after_pop", 64'(nf), 64'(5));

        // Jump with three fetches in flight
        do_reset(32'h1000);
        t_crdy = 1; t_rv = 0; t_irdy = 1;
        for (int i = 0; i < 3; i++) cycle();
        t_jump = 1; t_jpc = 32'h2000;
        cycle();
        chk("jump_gates_cmd", 64'(o_cv), 64'(0));
        t_jump = 0; t_rv = 1;
        cycle();
        chk("jump_first_cmd_valid", 64'(o_cv), 64'(1));
        chk("jump_first_cmd_pc", 64'(o_cpc), 64'(32'h2000));
        found = 0;
        for (int i = 0; i < 15; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
            if (o_iv && !found) begin
                found = 1;
                chk("jump_first_ins_pc", 64'(o_ipc), 64'(32'h2000));
            end
        end
        chk("jump_ins_seen", 64'(found), 64'(1));

        // Jump coinciding with a response and a pending pop
        do_reset(32'h1000);
        rv_pat = '{0, 0, 1, 0};
        t_crdy = 1; t_irdy = 0;
        for (int i = 0; i < 4; i++) begin
            t_rv = rv_pat[i] && (env_q.size() > 0);
            cycle();
        end
        t_jump = 1; t_jpc = 32'h4000; t_rv = 1; t_irdy = 1;
        cycle();
        chk("same_cycle_head_valid", 64'(o_iv), 64'(1));
        t_jump = 0; t_rv = 0;
        cycle();
        chk("same_cycle_flushed", 64'(o_iv), 64'(0));
        found = 0;
        for (int i = 0; i < 15; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
            if (o_iv && !found) begin
                found = 1;
                chk("same_cycle_first_ins_pc", 64'(o_ipc), 64'(32'h4000));
            end
        end
        chk("same_cycle_ins_seen", 64'(found), 64'(1));

        // Bus error on 0x1008 halts issue until a jump
        err_pc = 32'h1008;
        do_reset(32'h1000);
        t_crdy = 1; t_irdy = 1; found = 0;
        for (int i = 0; i < 10; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
            if (o_iv && o_ipc == 32'h1008) begin
                found = 1;
                chk("err_flag", 64'(o_ierr), 64'(1));
            end
        end
        chk("err_delivered", 64'(found), 64'(1));
        chk("err_halts_issue", 64'(o_cv), 64'(0));
        err_pc = 32'h1;
        t_jump = 1; t_jpc = 32'h3000; t_rv = 0;
        cycle();
        t_jump = 0;
        cycle();
        chk("err_resume_valid", 64'(o_cv), 64'(1));
        chk("err_resume_pc", 64'(o_cpc), 64'(32'h3000));

        // PC wrap, then reset in the middle of a burst
        do_reset(32'hFFFF_FFFC);
        t_crdy = 1; t_irdy = 1; t_rv = 0;
        cycle();
        chk("wrap_pc0", 64'(o_cpc), 64'(32'hFFFF_FFFC));
        t_rv = env_q.size() > 0;
        cycle();
        chk("wrap_pc1", 64'(o_cpc), 64'(32'h0));
        for (int i = 0; i < 2; i++) begin
            t_rv = env_q.size() > 0;
            cycle();
        end
        t_rst = 1; t_rpc = 32'h5000;
        cycle();
        chk("midrst_cmd_valid", 64'(o_cv), 64'(0));
        chk("midrst_ins_valid", 64'(o_iv), 64'(0));
        t_rst = 0; t_rv = 0;
        cycle();
        chk("post_rst_ins_valid", 64'(o_iv), 64'(0));
        chk("post_rst_cmd_valid", 64'(o_cv), 64'(1));
        chk("post_rst_cmd_pc", 64'(o_cpc), 64'(32'h5000));

        // Randomized traffic against the reference
        do_reset($urandom & ~32'h3);
        err_mod = 25;
        for (int i = 0; i < 3000; i++) begin
            t_rst = ($urandom_range(399) == 0);
            if (t_rst) t_rpc = $urandom & ~32'h3;
            t_jump = ($urandom_range(24) == 0);
            t_jpc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
            t_crdy = ($urandom_range(3) != 0);
            t_irdy = ($urandom_range(2) != 0);
            t_rv   = (env_q.size() > 0) ? ($urandom_range(2) != 0) : ($urandom_range(19) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
